// File: rtl/pinwheel_console_hub.sv
// pinwheel_console_hub: tag-decoded console TX FIFOs, debug register, registered reads.
// Define PINWHEEL_CONSOLE_HUB_TIMESTAMP_EN for a cycle counter at DEBUG_TAG offset 4.
module pinwheel_console_hub #(
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int BASE_TAG   = 4,
    parameter int DEBUG_TAG  = 15
) (
    input  logic                    clock,
    input  logic                    reset_in,
    input  logic [31:0]             bus_addr,
    input  logic [31:0]             bus_wdata,
    input  logic [3:0]              bus_wmask,
    input  logic                    bus_wren,
    input  logic                    bus_rden,
    output logic [31:0]             bus_rdata,
    output logic                    bus_hit,
    output logic [CHANNELS-1:0]     tx_valid,
    output logic [8*CHANNELS-1:0]   tx_data,
    input  logic [CHANNELS-1:0]     tx_ready,
    output logic [31:0]             debug_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0] tag;
    logic [4:0] ch_off;
    logic [2:0] ch_idx;
    logic [1:0] sel;
    logic       ch_hit;
    logic       dbg_hit;

    assign tag     = {1'b0, bus_addr[31:28]};
    assign sel     = bus_addr[3:2];
    assign ch_off  = tag - 5'(BASE_TAG);
    assign ch_hit  = (tag >= 5'(BASE_TAG)) && (ch_off < 5'(CHANNELS));
    assign ch_idx  = ch_off[2:0];
    assign dbg_hit = bus_addr[31:28] == 4'(DEBUG_TAG);

    logic unused_addr;
    assign unused_addr = ^{bus_addr[27:4], bus_addr[1:0]};

    // Padded to 8 so the 3-bit channel index always lands in range.
    logic [7:0][31:0] stat_w;
    logic [7:0]       en_w;

    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < CHANNELS) begin : g_on
            logic [7:0]    mem_q [FIFO_DEPTH];
            logic [AW-1:0] wp_q;
            logic [AW-1:0] wp_d;
            logic [AW-1:0] rp_q;
            logic [AW-1:0] rp_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          ovf_q;
            logic          ovf_d;
            logic          en_q;
            logic          en_d;
            logic          hit;
            logic          empty;
            logic          full;
            logic          valid;
            logic          pop;
            logic          wr_data;
            logic          wr_ctrl;
            logic          push;
            logic          flush;
            logic          clr;

            assign hit     = ch_hit && (ch_idx == 3'(g));
            assign wr_data = bus_wren && hit && sel == 2'd0 && bus_wmask[0];
            assign wr_ctrl = bus_wren && hit && sel == 2'd2 && bus_wmask[0];
            assign flush   = wr_ctrl && bus_wdata[1];
            assign clr     = bus_rden && hit && sel == 2'd1;
            assign empty   = cnt_q == '0;
            assign full    = cnt_q == CW'(FIFO_DEPTH);
            assign valid   = !empty && en_q;
            assign pop     = valid && tx_ready[g];
            // A pop frees the slot in the same cycle, so a full FIFO still accepts.
            assign push    = wr_data && (!full || pop);

            always_comb begin
                wp_d  = wp_q;
                rp_d  = rp_q;
                cnt_d = cnt_q;
                en_d  = wr_ctrl ? bus_wdata[0] : en_q;
                ovf_d = clr ? 1'b0 : (ovf_q | (wr_data && full && !pop));
                if (flush) begin
                    wp_d  = '0;
                    rp_d  = '0;
                    cnt_d = '0;
                end else begin
                    if (push)
                        wp_d = wp_q + AW'(1);
                    if (pop)
                        rp_d = rp_q + AW'(1);
                    cnt_d = cnt_q + CW'(push) - CW'(pop);
                end
            end

            always_ff @(posedge clock) begin
                if (reset_in) begin
                    wp_q  <= '0;
                    rp_q  <= '0;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                    en_q  <= 1'b1;
                end else begin
                    wp_q  <= wp_d;
                    rp_q  <= rp_d;
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_d;
                    en_q  <= en_d;
                end
            end

            always_ff @(posedge clock) begin
                if (push)
                    mem_q[wp_q] <= bus_wdata[7:0];
            end

            assign tx_valid[g]       = valid;
            assign tx_data[8*g +: 8] = empty ? 8'h00 : mem_q[rp_q];
            assign stat_w[g]         = {16'h0, 8'(cnt_q), 5'h0, ovf_q, full, empty};
            assign en_w[g]           = en_q;
        end else begin : g_off
            assign stat_w[g] = '0;
            assign en_w[g]   = 1'b0;
        end
    end

    logic [31:0] dbg_q;
    logic [31:0] dbg_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        hit_q;
    logic        hit_d;
    logic [31:0] ts_val;

`ifdef PINWHEEL_CONSOLE_HUB_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge clock) begin
        if (reset_in)
            ts_q <= '0;
        else
            ts_q <= ts_q + 32'd1;
    end
    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    always_comb begin
        dbg_d = dbg_q;
        if (bus_wren && dbg_hit && sel == 2'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_wmask[b])
                    dbg_d[8*b +: 8] = bus_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        hit_d   = 1'b0;
        if (bus_rden && ch_hit) begin
            hit_d = 1'b1;
            if (sel == 2'd1)
                rdata_d = stat_w[ch_idx];
            else if (sel == 2'd2)
                rdata_d = {31'h0, en_w[ch_idx]};
        end else if (bus_rden && dbg_hit) begin
            hit_d = 1'b1;
            if (sel == 2'd0)
                rdata_d = dbg_q;
            else if (sel == 2'd1)
                rdata_d = ts_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_in) begin
            dbg_q   <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            dbg_q   <= dbg_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_hit   = hit_q;
    assign debug_out = dbg_q;
endmodule
